// File: rtl/pipe_pkg.sv
// Types and constants shared by the fetch/decode pipeline stages.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

  localparam logic [31:0] RV_NOP = 32'h0000_0013;  // ADDI x0,x0,0

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_beat_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic two-entry skid buffer: registered in_ready, full throughput, synchronous flush.
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  skid_state_e  state_r, state_nx_s;
  logic [W-1:0] main_r, main_nx_s;
  logic [W-1:0] skid_r, skid_nx_s;
  logic         in_ready_r;
  logic         out_valid_r;
  logic         accept_s;
  logic         drain_s;

  assign accept_s  = in_valid & in_ready_r;
  assign drain_s   = out_valid_r & out_ready;
  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = main_r;

  // Next-state and entry movement; flush overrides every handshake event.
  always_comb begin
    state_nx_s = state_r;
    main_nx_s  = main_r;
    skid_nx_s  = skid_r;
    if (flush) begin
      state_nx_s = EMPTY;
    end else begin
      case (state_r)
        EMPTY: begin
          if (accept_s) begin
            main_nx_s  = in_data;
            state_nx_s = BUSY;
          end else begin
            state_nx_s = EMPTY;
          end
        end
        BUSY: begin
          if (accept_s && drain_s) begin
            main_nx_s = in_data;
          end else if (accept_s) begin
            skid_nx_s  = in_data;
            state_nx_s = FULL;
          end else if (drain_s) begin
            state_nx_s = EMPTY;
          end else begin
            state_nx_s = BUSY;
          end
        end
        FULL: begin
          if (drain_s) begin
            main_nx_s  = skid_r;
            state_nx_s = BUSY;
          end else begin
            state_nx_s = FULL;
          end
        end
        default: begin
          state_nx_s = EMPTY;
        end
      endcase
    end
  end

  // State and handshake flags are registered so nothing combinational reaches fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= EMPTY;
      main_r      <= '0;
      skid_r      <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      main_r      <= main_nx_s;
      skid_r      <= skid_nx_s;
      in_ready_r  <= (state_nx_s != FULL);
      out_valid_r <= (state_nx_s != EMPTY);
    end
  end

endmodule

// File: rtl/if_id_skid_stage.sv
// IF/ID stage register: skid-buffered PC/instruction with flush, NOP/RESET_PC shown when idle.
module if_id_skid_stage
  import pipe_pkg::*;
#(
  parameter int          PC_W      = 32,
  parameter int          INSTR_W   = 32,
  parameter logic [31:0] NOP_INSTR = RV_NOP,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr
);

  localparam int                 PAY_W   = PC_W + INSTR_W;
  localparam logic [INSTR_W-1:0] IDLE_INSTR = INSTR_W'(NOP_INSTR);
  localparam logic [PC_W-1:0]    IDLE_PC    = PC_W'(RESET_PC);

  logic [PAY_W-1:0] pay_in_s;
  logic [PAY_W-1:0] pay_out_s;
  logic             buf_valid_s;

  assign pay_in_s = {in_pc, in_instr};

  pipe_skid_buf #(
    .W (PAY_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (pay_in_s),
    .out_valid (buf_valid_s),
    .out_ready (out_ready),
    .out_data  (pay_out_s)
  );

  // Stale payload is never visible: an empty stage presents a NOP bubble.
  assign out_valid = buf_valid_s;
  assign out_pc    = buf_valid_s ? pay_out_s[PAY_W-1 -: PC_W] : IDLE_PC;
  assign out_instr = buf_valid_s ? pay_out_s[INSTR_W-1:0]     : IDLE_INSTR;

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Scoreboard bench for if_id_skid_stage: directed scenarios plus a random handshake/flush run.
module tb_if_id_skid_stage;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = 32'h0;
  logic [31:0] in_instr = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  int checks = 0;
  int errors = 0;

  fetch_beat_t mq[$];
  logic [31:0] drained[$];
  logic [31:0] exp_list[$];

  if_id_skid_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                      input logic ordy, input logic fl);
    in_valid  = v;
    in_pc     = pc;
    in_instr  = ins;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic cmp_drained(input string nm);
    chk({nm, "_count"}, 64'(drained.size()), 64'(exp_list.size()));
    for (int i = 0; i < drained.size() && i < exp_list.size(); i++)
      chk({nm, "_order"}, 64'(drained[i]), 64'(exp_list[i]));
    drained.delete();
  endtask

  // Monitor: checks handshake flags, bubble output, stability, and drained order against the model queue.
  initial begin
    fetch_beat_t e;
    bit          stall_prev = 1'b0;
    logic [31:0] hold_pc = 32'h0;
    logic [31:0] hold_instr = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mq.delete();
        stall_prev = 1'b0;
      end else begin
        chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
        chk("in_ready", 64'(in_ready), 64'(mq.size() < 2));
        if (!out_valid) begin
          chk("bubble_instr", 64'(out_instr), 64'(32'h0000_0013));
          chk("bubble_pc", 64'(out_pc), 64'(32'h0000_0000));
        end
        if (stall_prev) begin
          chk("stable_valid", 64'(out_valid), 64'(1'b1));
          chk("stable_pc", 64'(out_pc), 64'(hold_pc));
          chk("stable_instr", 64'(out_instr), 64'(hold_instr));
        end
        if (out_valid && out_ready) begin
          if (mq.size() > 0) begin
            e = mq.pop_front();
            chk("drain_pc", 64'(out_pc), 64'(e.pc));
            chk("drain_instr", 64'(out_instr), 64'(e.instr));
          end
          drained.push_back(out_pc);
        end
        if (flush) mq.delete();
        else if (in_valid && in_ready) mq.push_back('{pc: in_pc, instr: in_instr});
        stall_prev = out_valid && !out_ready && !flush;
        hold_pc    = out_pc;
        hold_instr = out_instr;
      end
    end
  end

  initial begin
    bit          have;
    bit          acc;
    bit          fl;
    bit          ordy;
    logic [31:0] rpc;

    #12 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Streaming at full throughput.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 32'h100 + 32'(4 * i), 32'h0000_00A0 + 32'(i), 1'b1, 1'b0);
      if (i == 0) begin
        chk("stream_latency_valid", 64'(out_valid), 64'(1'b1));
        chk("stream_latency_pc", 64'(out_pc), 64'(32'h100));
      end
      chk("stream_in_ready", 64'(in_ready), 64'(1'b1));
    end
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    exp_list = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110, 32'h114, 32'h118, 32'h11C};
    cmp_drained("stream");

    // Backpressure: 0x104 lands in skid, 0x108 must wait.
    step(1'b1, 32'h100, 32'h0000_00B0, 1'b0, 1'b0);
    step(1'b1, 32'h104, 32'h0000_00B1, 1'b0, 1'b0);
    chk("bp_in_ready_low", 64'(in_ready), 64'(1'b0));
    chk("bp_hold_pc", 64'(out_pc), 64'(32'h100));
    step(1'b1, 32'h108, 32'h0000_00B2, 1'b0, 1'b0);
    chk("bp_still_pc", 64'(out_pc), 64'(32'h100));
    step(1'b1, 32'h108, 32'h0000_00B2, 1'b1, 1'b0);
    step(1'b1, 32'h108, 32'h0000_00B2, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    exp_list = '{32'h100, 32'h104, 32'h108};
    cmp_drained("backpressure");

    // Flush while FULL drops both held beats.
    step(1'b1, 32'h200, 32'h0000_00C0, 1'b0, 1'b0);
    step(1'b1, 32'h204, 32'h0000_00C1, 1'b0, 1'b0);
    step(1'b1, 32'h208, 32'h0000_00C2, 1'b0, 1'b1);
    chk("flush_full_valid", 64'(out_valid), 64'(1'b0));
    chk("flush_full_instr", 64'(out_instr), 64'(32'h0000_0013));
    chk("flush_full_ready", 64'(in_ready), 64'(1'b1));
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    exp_list = {};
    cmp_drained("flush_full");

    // Flush with simultaneous accept and drain.
    step(1'b1, 32'h300, 32'h0000_00D0, 1'b1, 1'b0);
    step(1'b1, 32'h304, 32'h0000_00D1, 1'b1, 1'b1);
    chk("flush_ad_valid", 64'(out_valid), 64'(1'b0));
    chk("flush_ad_ready", 64'(in_ready), 64'(1'b1));
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    exp_list = '{32'h300};
    cmp_drained("flush_ad");

    // Asynchronous reset mid-cycle with beats held and fetch still streaming.
    step(1'b1, 32'h400, 32'h0000_00E0, 1'b0, 1'b0);
    step(1'b1, 32'h404, 32'h0000_00E1, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", 64'(out_valid), 64'(1'b0));
    chk("rst_instr", 64'(out_instr), 64'(32'h0000_0013));
    chk("rst_pc", 64'(out_pc), 64'(32'h0000_0000));
    chk("rst_ready", 64'(in_ready), 64'(1'b1));
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    exp_list = {};
    cmp_drained("reset");

    // Random handshakes and flushes; fetch holds an offered beat until taken.
    have = 1'b0;
    rpc  = 32'h1000;
    for (int i = 0; i < 10000; i++) begin
      if (!have) begin
        have = ($urandom_range(0, 3) != 0);
        if (have) rpc = rpc + 32'd4;
      end
      fl   = ($urandom_range(0, 19) == 0);
      ordy = ($urandom_range(0, 2) != 0);
      acc  = have && in_ready;
      step(have, rpc, rpc ^ 32'hA5A5_0000, ordy, fl);
      if (acc || fl) have = 1'b0;
    end
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("random_final_empty", 64'(out_valid), 64'(1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_id_skid_stage.md
Name: if_id_skid_stage

Overview:
- Parametrised IF/ID pipeline stage register that replaces the plain always-load register.
- Carries PC and instruction from fetch to decode over a valid/ready handshake.
- A 2-entry skid buffer sustains one transfer per cycle while keeping in_ready registered, so there is no combinational ready path back to fetch.
- Adds a synchronous flush for branch and jump redirects; the flush inserts a bubble that drives a NOP.

Parameters:
- PC_W, 32: width of the PC field.
- INSTR_W, 32: width of the instruction field.
- NOP_INSTR, 32'h0000_0013: instruction driven when no valid beat is held (ADDI x0,x0,0).
- RESET_PC, 32'h0000_0000: PC value driven when no valid beat is held.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous reset, active-low.
- flush  in  1  synchronous flush of all held beats.
- in_valid  in  1  fetch presents a beat.
- in_ready  out  1  stage can accept a beat; driven directly from a flop.
- in_pc  in  PC_W  fetch PC.
- in_instr  in  INSTR_W  fetched instruction.
- out_valid  out  1  decode beat valid.
- out_ready  in  1  decode accepts the beat.
- out_pc  out  PC_W  PC to decode.
- out_instr  out  INSTR_W  instruction to decode.

Behaviour:
- Reset: rst_n low asynchronously forces state EMPTY, out_valid=0, in_ready=1, out_pc=RESET_PC, out_instr=NOP_INSTR. The skid entry is invalidated.
- Transfer definitions: accept = in_valid & in_ready; drain = out_valid & out_ready.
- State EMPTY (no main entry, no skid entry):
  - accept: load the beat into main and go to BUSY.
- State BUSY (main entry valid, skid empty):
  - accept & drain: main takes the new beat; stay in BUSY.
  - accept & !drain: new beat goes to skid; go to FULL; in_ready=0 from the next cycle.
  - !accept & drain: go to EMPTY.
  - otherwise: hold.
- State FULL (main and skid both valid, in_ready=0):
  - drain: skid moves to main and skid is cleared; go to BUSY; in_ready=1 next cycle.
  - otherwise: hold.
- in_ready = (state != FULL), registered. in_valid while in FULL is not an accept; fetch must hold its beat.
- Latency: an accepted beat appears on out_* the following cycle when the stage is EMPTY, or on a BUSY-with-drain cycle. Throughput is 1 beat per cycle while out_ready=1.
- Ordering: beats leave strictly in acceptance order, with no loss and no duplication.
- Output stability: while out_valid=1 & out_ready=0, out_pc and out_instr must not change.
- Invalid output: whenever out_valid=0, out_pc=RESET_PC and out_instr=NOP_INSTR. Stale data is never shown.
- Flush: flush=1 at a clock edge forces EMPTY, in_ready=1 and NOP/RESET_PC outputs next cycle. Flush has priority over all events:
  - a beat accepted in the flush cycle is discarded;
  - a beat drained in the flush cycle counts as consumed by decode.
- Flush while FULL: both held beats are dropped.
- Reset mid-transfer: all beats are lost; no partial state survives.
- Width rules: fields are copied unchanged with no arithmetic. NOP_INSTR and RESET_PC are truncated or zero-extended to INSTR_W and PC_W.

Decomposition:
- Shared package pipe_pkg:
  - state enum {EMPTY, BUSY, FULL};
  - RV_NOP constant 32'h0000_0013;
  - a typedef for the fetch beat struct {pc, instr}.
- One sub-module is natural: pipe_skid_buf, a generic payload-width skid buffer with flush. if_id_skid_stage instantiates it with a {pc, instr} payload and applies the NOP/RESET_PC masking on the output.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with an in_valid stream → out_valid=0, out_instr=0x00000013, out_pc=0, in_ready=1, immediately and with no clock edge needed.
- Streaming: 8 beats, pc=0x100..0x11C step 4, instr=0xA0..0xA7, out_ready=1 → one beat per cycle, 1-cycle latency, order preserved, in_ready never drops.
- Backpressure: out_ready=0 after beat pc=0x100 is shown, fetch offers 0x104 then 0x108 →
  - 0x104 goes to skid; in_ready=0 next cycle; out_pc holds 0x100;
  - on out_ready=1, the output order is 0x100, 0x104, 0x108.
- Flush in FULL: hold 0x200 and 0x204, pulse flush → next cycle out_valid=0, out_instr=0x00000013, in_ready=1; 0x200 and 0x204 never appear.
- Flush with simultaneous accept and drain: BUSY with 0x300, out_ready=1, in_valid with 0x304, flush=1 → 0x300 counts as consumed, 0x304 is dropped, state is EMPTY.
- Random: random in_valid/out_ready/flush for 10k cycles against a scoreboard → zero mismatches and the stability assertion holds.
